// File: rtl/counter_button_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter_button_control                                     |
// | Description : Push-button front end for the up/down enabled LED counter. |
// |               Each raw button is synchronised (2 flops), debounced and   |
// |               edge-detected; a STOPPED/RUNNING machine and a direction   |
// |               toggle drive the counter's control levels.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   DEBOUNCE_CYCLES : stable cycles needed to accept a level (2..2^CNT_W-1)|
// |   CNT_W           : width of each debounce counter                       |
// | Ports                                                                    |
// |   CLK        in  : system clock, rising edge                             |
// |   RESET      in  : asynchronous active-low reset                         |
// |   BTN_RUN    in  : raw button, press toggles run/stop                    |
// |   BTN_DIR    in  : raw button, press toggles count direction             |
// |   BTN_CLR    in  : raw button, press clears the counter                  |
// |   CTR_ENABLE out : 1 while RUNNING                                       |
// |   CTR_CNTRL  out : 1 = count up, 0 = count down                          |
// |   CTR_CLEAR  out : one-cycle synchronous clear pulse                     |
// |   BTN_STATE  out : debounced levels {CLR, DIR, RUN}                      |
// | Build option                                                             |
// |   DIR_LOCK_EN : when defined, direction presses are ignored in RUNNING   |
// +--------------------------------------------------------------------------+
module counter_button_control #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_RUN,
  input  logic       BTN_DIR,
  input  logic       BTN_CLR,
  output logic       CTR_ENABLE,
  output logic       CTR_CNTRL,
  output logic       CTR_CLEAR,
  output logic [2:0] BTN_STATE
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Bit order everywhere: [0]=RUN, [1]=DIR, [2]=CLR
  logic [2:0] w_raw;
  logic [2:0] w_db;
  logic [2:0] w_press;
  logic       w_dir_ok;
  state_t     r_state;

  assign w_raw = {BTN_CLR, BTN_DIR, BTN_RUN};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic             r_db_q;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_db   <= 1'b0;
        r_db_q <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_s1   <= w_raw[gi];
        r_s2   <= r_s1;
        r_db_q <= r_db;
        // Any return to the accepted level restarts the stability count.
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_db[gi]    = r_db;
    // Rising edge of the accepted level only; releases generate no event.
    assign w_press[gi] = r_db & ~r_db_q;
  end

`ifdef DIR_LOCK_EN
  // Lock is judged on the current state, so a run+dir press from RUNNING
  // does not change direction even though the machine stops.
  assign w_dir_ok = w_press[1] & (r_state == ST_STOPPED);
`else
  assign w_dir_ok = w_press[1];
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_STOPPED;
      CTR_ENABLE <= 1'b0;
      CTR_CNTRL  <= 1'b1;
      CTR_CLEAR  <= 1'b0;
      BTN_STATE  <= 3'b000;
    end else begin
      BTN_STATE <= w_db;
      CTR_CLEAR <= 1'b0;
      if (w_press[2]) begin
        // Clear wins over any run/dir press in the same cycle.
        r_state    <= ST_STOPPED;
        CTR_ENABLE <= 1'b0;
        CTR_CNTRL  <= 1'b1;
        CTR_CLEAR  <= 1'b1;
      end else begin
        if (w_press[0]) begin
          if (r_state == ST_RUNNING) begin
            r_state    <= ST_STOPPED;
            CTR_ENABLE <= 1'b0;
          end else begin
            r_state    <= ST_RUNNING;
            CTR_ENABLE <= 1'b1;
          end
        end
        if (w_dir_ok) begin
          CTR_CNTRL <= ~CTR_CNTRL;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_button_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_counter_button_control                                  |
// | Description : Directed self-checking bench for counter_button_control    |
// |               with DEBOUNCE_CYCLES=4, CNT_W=3 (latency 6 edges).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_counter_button_control;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BTN_RUN = 1'b0;
  logic       BTN_DIR = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic       CTR_ENABLE;
  logic       CTR_CNTRL;
  logic       CTR_CLEAR;
  logic [2:0] BTN_STATE;

  int checks = 0;
  int errors = 0;
  logic       exp_dir;
  logic [7:0] pat;

  counter_button_control #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN_RUN   (BTN_RUN),
    .BTN_DIR   (BTN_DIR),
    .BTN_CLR   (BTN_CLR),
    .CTR_ENABLE(CTR_ENABLE),
    .CTR_CNTRL (CTR_CNTRL),
    .CTR_CLEAR (CTR_CLEAR),
    .BTN_STATE (BTN_STATE)
  );

  always #5 CLK = ~CLK;

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // After setting inputs at posedge+1, the next posedge is edge 0,
  // so tick(k+1) lands just after edge k.
  initial begin
    // Reset values with every button held high
    RESET = 1'b0; BTN_RUN = 1'b1; BTN_DIR = 1'b1; BTN_CLR = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("rst_en",    {2'b0, CTR_ENABLE}, 3'b000);
      chk("rst_dir",   {2'b0, CTR_CNTRL},  3'b001);
      chk("rst_clr",   {2'b0, CTR_CLEAR},  3'b000);
      chk("rst_state", BTN_STATE,          3'b000);
    end
    BTN_RUN = 1'b0; BTN_DIR = 1'b0; BTN_CLR = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(3);

    // Clean press: enable rises at edge 6
    BTN_RUN = 1'b1;
    tick(6);
    chk("press1_e5_en",    {2'b0, CTR_ENABLE}, 3'b000);
    chk("press1_e5_state", BTN_STATE,          3'b000);
    tick(1);
    chk("press1_e6_en",    {2'b0, CTR_ENABLE}, 3'b001);
    chk("press1_e6_state", BTN_STATE,          3'b001);
    BTN_RUN = 1'b0;
    tick(8);
    chk("release_en",    {2'b0, CTR_ENABLE}, 3'b001);
    chk("release_state", BTN_STATE,          3'b000);

    // Second press stops; held button gives no repeat
    BTN_RUN = 1'b1;
    tick(6);
    chk("press2_e5_en", {2'b0, CTR_ENABLE}, 3'b001);
    tick(1);
    chk("press2_e6_en", {2'b0, CTR_ENABLE}, 3'b000);
    tick(20);
    chk("held_en", {2'b0, CTR_ENABLE}, 3'b000);
    BTN_RUN = 1'b0;
    tick(8);

    // Bounce rejection: 1,1,1,0,1,1,1,1 then held; final rise sampled at edge 4
    pat = 8'b1111_0111;
    for (int i = 0; i < 8; i++) begin
      BTN_DIR = pat[i];
      tick(1);
    end
    chk("bounce_e7_dir", {2'b0, CTR_CNTRL}, 3'b001);
    tick(2);
    chk("bounce_e9_dir", {2'b0, CTR_CNTRL}, 3'b001);
    tick(1);
    chk("bounce_e10_dir", {2'b0, CTR_CNTRL}, 3'b000);
    BTN_DIR = 1'b0;
    tick(8);
    chk("bounce_after_dir", {2'b0, CTR_CNTRL}, 3'b000);

    // Get into RUNNING, direction down
    BTN_RUN = 1'b1;
    tick(7);
    chk("run_down_en", {2'b0, CTR_ENABLE}, 3'b001);
    BTN_RUN = 1'b0;
    tick(8);

    // Clear and run accepted together: clear wins
    BTN_CLR = 1'b1; BTN_RUN = 1'b1;
    tick(6);
    chk("clr_e5_clr", {2'b0, CTR_CLEAR},  3'b000);
    chk("clr_e5_en",  {2'b0, CTR_ENABLE}, 3'b001);
    tick(1);
    chk("clr_e6_clr",   {2'b0, CTR_CLEAR},  3'b001);
    chk("clr_e6_en",    {2'b0, CTR_ENABLE}, 3'b000);
    chk("clr_e6_dir",   {2'b0, CTR_CNTRL},  3'b001);
    chk("clr_e6_state", BTN_STATE,          3'b101);
    tick(1);
    chk("clr_e7_clr", {2'b0, CTR_CLEAR}, 3'b000);
    tick(10);
    chk("clr_held_clr", {2'b0, CTR_CLEAR},  3'b000);
    chk("clr_held_en",  {2'b0, CTR_ENABLE}, 3'b000);
    BTN_CLR = 1'b0; BTN_RUN = 1'b0;
    tick(8);

    // Direction press while RUNNING (locked only with DIR_LOCK_EN)
    exp_dir = 1'b1;
    BTN_RUN = 1'b1;
    tick(7);
    BTN_RUN = 1'b0;
    tick(8);
    chk("lock_running_en", {2'b0, CTR_ENABLE}, 3'b001);
    BTN_DIR = 1'b1;
    tick(7);
`ifndef DIR_LOCK_EN
    exp_dir = ~exp_dir;
`endif
    chk("dir_in_running", {2'b0, CTR_CNTRL}, {2'b0, exp_dir});
    BTN_DIR = 1'b0;
    tick(8);
    BTN_RUN = 1'b1;
    tick(7);
    chk("stop_en", {2'b0, CTR_ENABLE}, 3'b000);
    BTN_RUN = 1'b0;
    tick(8);
    BTN_DIR = 1'b1;
    tick(7);
    exp_dir = ~exp_dir;
    chk("dir_in_stopped", {2'b0, CTR_CNTRL}, {2'b0, exp_dir});
    BTN_DIR = 1'b0;
    tick(8);

    // Run and dir together from STOPPED: both act
    BTN_RUN = 1'b1; BTN_DIR = 1'b1;
    tick(6);
    chk("both_e5_dir", {2'b0, CTR_CNTRL}, {2'b0, exp_dir});
    tick(1);
    exp_dir = ~exp_dir;
    chk("both_e6_en",  {2'b0, CTR_ENABLE}, 3'b001);
    chk("both_e6_dir", {2'b0, CTR_CNTRL},  {2'b0, exp_dir});
    BTN_RUN = 1'b0; BTN_DIR = 1'b0;
    tick(8);

    // Mid-debounce reset: cnt=2 after edge 3, reset for 3 cycles
    BTN_RUN = 1'b1;
    tick(4);
    RESET = 1'b0;
    #1;
    chk("midrst_en",    {2'b0, CTR_ENABLE}, 3'b000);
    chk("midrst_dir",   {2'b0, CTR_CNTRL},  3'b001);
    chk("midrst_state", BTN_STATE,          3'b000);
    tick(3);
    RESET = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("midrst_early_en", {2'b0, CTR_ENABLE}, 3'b000);
    end
    tick(1);
    chk("midrst_e6_en", {2'b0, CTR_ENABLE}, 3'b001);
    BTN_RUN = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_button_control.md
# counter_button_control

Front-end controller for the up/down enabled LED counter: turns three raw push-buttons into that counter's `CTR_ENABLE`, `CTR_CNTRL` and a synchronous clear.
- Each button is synchronised, debounced and edge-detected.
- A two-state run/stop machine and a direction toggle hold the counter's control levels.
- Sits between the board buttons and the counter block, in the same clock domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz). Legal range 2 to 2^CNT_W−1.
- `CNT_W`, default 20: width of each debounce counter.

Ports:
- `CLK` in 1: system clock; all logic on the rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `BTN_RUN` in 1: raw, asynchronous, active-high; each accepted press toggles run/stop.
- `BTN_DIR` in 1: raw, asynchronous, active-high; each accepted press toggles direction.
- `BTN_CLR` in 1: raw, asynchronous, active-high; an accepted press clears the counter.
- `CTR_ENABLE` out 1: registered; 1 while RUNNING.
- `CTR_CNTRL` out 1: registered; 1 = count up, 0 = count down.
- `CTR_CLEAR` out 1: registered one-cycle pulse; the counter uses it as its synchronous reset.
- `BTN_STATE` out 3: registered debounced levels {CLR, DIR, RUN}, for LEDs or debug.

## Operation
- **Reset** (`RESET`=0, asynchronous). Sets:
  - state = STOPPED; `CTR_ENABLE`=0; `CTR_CNTRL`=1 (up); `CTR_CLEAR`=0; `BTN_STATE`=0.
  - All synchronisers, debounced levels, previous-level registers and debounce counters = 0.
  - Release is sampled on `CLK`; the first active edge after release is edge 0.
- **Synchroniser.** Each button passes through two flops (s1, s2).
- **Debouncer** (per button: counter `cnt`, accepted level `db`):
  - If s2 == db: `cnt` <= 0.
  - Else if `cnt` == DEBOUNCE_CYCLES−1: `db` <= s2 and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any bounce back to the accepted level restarts the count from 0. Release is debounced identically.
- **Edge detect.** `db_q` <= `db`; press = `db` & ~`db_q`. Only presses act; releases produce no event.
- **Control FSM** (two states, STOPPED and RUNNING):
  - run press: STOPPED→RUNNING, RUNNING→STOPPED.
  - dir press: `CTR_CNTRL` <= ~`CTR_CNTRL`, in either state.
  - clr press: `CTR_CLEAR` <= 1 for exactly one cycle; state <= STOPPED; `CTR_CNTRL` <= 1.
  - `CTR_ENABLE` = (state == RUNNING), registered together with the state.
- **Simultaneous presses:**
  - clr overrides run and dir in the same cycle.
  - run and dir in the same cycle both take effect.
- **Held buttons.** A button held indefinitely produces one press only. There is no auto-repeat.

## Timing
- Raw input goes high and stays stable; s1 first captures it at edge 0.
  - s2 = 1 after edge 1.
  - `cnt` increments on edges 2 through DEBOUNCE_CYCLES; `db` = 1 after edge DEBOUNCE_CYCLES+1.
  - `CTR_ENABLE` / `CTR_CNTRL` / `CTR_CLEAR` update at edge DEBOUNCE_CYCLES+2.
- Press-to-output latency is DEBOUNCE_CYCLES+2 edges after the first sampled high.
- `BTN_STATE` mirrors `db` with one cycle of register delay, i.e. it updates at edge DEBOUNCE_CYCLES+2.
- `CTR_CLEAR` is high for one cycle only, then returns to 0 on the next edge regardless of the button.
- Reset asserted mid-debounce or mid-pulse:
  - All state returns to reset values immediately.
  - A button held through reset release must be debounced afresh and counts as a new press once accepted, since `db_q`=0.

## Configuration
- `DIR_LOCK_EN` defined: dir presses are ignored while state is RUNNING; `CTR_CNTRL` can change only in STOPPED or via clear.
  - A simultaneous run+dir press from RUNNING is ignored for direction, since the lock is evaluated on the current state.
- `DIR_LOCK_EN` undefined: dir presses toggle direction in any state, as described in Operation.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and `CNT_W`=3.
- **Reset values:** hold `RESET`=0 with all buttons high → `CTR_ENABLE`=0, `CTR_CNTRL`=1, `CTR_CLEAR`=0, `BTN_STATE`=000 throughout.
- **Clean press:** `BTN_RUN` stable high from edge 0 → `CTR_ENABLE` rises at edge 6; second press after release → falls 6 edges after its first sampled high.
- **Bounce rejection:** `BTN_DIR` pattern 1,1,1,0,1,1,1,1 (one value per cycle) → single toggle of `CTR_CNTRL` (1→0), taking effect 6 edges after the final rising sample.
- **Clear priority:** RUNNING and down; `BTN_CLR` and `BTN_RUN` accepted in the same cycle → one-cycle `CTR_CLEAR`=1, `CTR_ENABLE`=0, `CTR_CNTRL`=1.
- **Mid-debounce reset:** assert `RESET` with `cnt`=2 while `BTN_RUN` is high, release after 3 cycles, keep the button high → `CTR_ENABLE` rises 6 edges after release; no earlier change.
- **DIR_LOCK_EN build:** in RUNNING, press `BTN_DIR` → `CTR_CNTRL` unchanged; stop, then press `BTN_DIR` → toggles. Without the macro, the RUNNING press toggles.
